// File: rtl/neosd_pkg.sv
// rtl/neosd_pkg.sv - shared constants, types and helpers for the NEOSD data path
package neosd_pkg;

  localparam int NEOSD_FIFO_DEPTH  = 128;
  localparam int NEOSD_BLOCK_WORDS = 128;

  typedef logic [31:0]                        neosd_word_t;
  typedef logic [$clog2(NEOSD_FIFO_DEPTH):0] neosd_level_t;

  // Reverse byte order of a 32-bit word (LE CPU word -> MSB-first on DAT)
  function automatic neosd_word_t neosd_bswap(input neosd_word_t w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/neosd_fifo_ram.sv
// rtl/neosd_fifo_ram.sv - DEPTH x WIDTH storage, synchronous write, asynchronous read
module neosd_fifo_ram #(
  parameter int DEPTH = 128,
  parameter int WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port; contents are intentionally not reset so this maps to distributed RAM
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/neosd_dat_fifo.sv
// rtl/neosd_dat_fifo.sv - FWFT word FIFO between the data register and the DAT FSM (option: NEOSD_DAT_FIFO_BSWAP_EN)
module neosd_dat_fifo
  import neosd_pkg::*;
#(
  parameter int DEPTH       = NEOSD_FIFO_DEPTH,
  parameter int WIDTH       = 32,
  parameter int BLOCK_WORDS = NEOSD_BLOCK_WORDS
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     clr_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     wr_valid_i,
  output logic                     wr_ready_o,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     rd_valid_o,
  input  logic                     rd_ready_i,
  output logic [$clog2(DEPTH):0]   level_o,
  input  logic [$clog2(DEPTH):0]   thresh_i,
  output logic                     thresh_o,
  output logic                     ovf_o,
  output logic                     udf_o,
  output logic                     rd_blk_done_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

  logic [AW-1:0]    wptr, rptr;
  logic [LW-1:0]    level;
  logic [BW-1:0]    blk_cnt;
  logic             ovf, udf, blk_done;
  logic             push, pop;
  logic [WIDTH-1:0] wdata;

`ifdef NEOSD_DAT_FIFO_BSWAP_EN
  if (WIDTH != 32) begin : g_bswap_width_check
    $error("neosd_dat_fifo: byte swap requires WIDTH == 32");
  end
  assign wdata = neosd_bswap(wr_data_i);
`else
  assign wdata = wr_data_i;
`endif

  assign wr_ready_o    = (level != LW'(DEPTH));
  assign rd_valid_o    = (level != '0);
  assign level_o       = level;
  assign ovf_o         = ovf;
  assign udf_o         = udf;
  assign rd_blk_done_o = blk_done;

  // A flush wins over any transfer in the same cycle
  assign push = wr_valid_i && wr_ready_o && !clr_i;
  assign pop  = rd_ready_i && rd_valid_o && !clr_i;

  neosd_fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (push),
    .waddr_i (wptr),
    .wdata_i (wdata),
    .raddr_i (rptr),
    .rdata_o (rd_data_o)
  );

  // Pointers wrap naturally (DEPTH is a power of two); level tracks occupancy separately
  always_ff @(posedge clk_i) begin
    if (!rstn_i || clr_i) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Sticky error flags and block-boundary tracking; the boundary pulse is registered
  always_ff @(posedge clk_i) begin
    if (!rstn_i || clr_i) begin
      ovf      <= 1'b0;
      udf      <= 1'b0;
      blk_cnt  <= '0;
      blk_done <= 1'b0;
    end else begin
      if (wr_valid_i && !wr_ready_o) ovf <= 1'b1;
      if (rd_ready_i && !rd_valid_o) udf <= 1'b1;
      blk_done <= 1'b0;
      if (pop) begin
        if (blk_cnt == BW'(BLOCK_WORDS - 1)) begin
          blk_cnt  <= '0;
          blk_done <= 1'b1;
        end else begin
          blk_cnt <= blk_cnt + 1'b1;
        end
      end
    end
  end

  // Threshold compare against the registered level; out-of-range thresholds saturate
  always_comb begin
    thresh_o = 1'b0;
    if (thresh_i == '0) begin
      thresh_o = 1'b1;
    end else if (thresh_i > LW'(DEPTH)) begin
      thresh_o = 1'b0;
    end else begin
      thresh_o = (level >= thresh_i);
    end
  end

endmodule

// File: tb/tb_neosd_dat_fifo.sv
// tb/tb_neosd_dat_fifo.sv - scoreboard bench for neosd_dat_fifo
module tb_neosd_dat_fifo;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] wr_data = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [7:0]  level;
  logic [7:0]  thresh = 8'd64;
  logic        thresh_out;
  logic        ovf, udf, blk_done;

  int checks = 0;
  int failures = 0;
  int blk_pulses = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  neosd_dat_fifo #(
    .DEPTH       (128),
    .WIDTH       (32),
    .BLOCK_WORDS (128)
  ) dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .clr_i         (clr),
    .wr_data_i     (wr_data),
    .wr_valid_i    (wr_valid),
    .wr_ready_o    (wr_ready),
    .rd_data_o     (rd_data),
    .rd_valid_o    (rd_valid),
    .rd_ready_i    (rd_ready),
    .level_o       (level),
    .thresh_i      (thresh),
    .thresh_o      (thresh_out),
    .ovf_o         (ovf),
    .udf_o         (udf),
    .rd_blk_done_o (blk_done)
  );

  function automatic logic [31:0] xf(input logic [31:0] v);
`ifdef NEOSD_DAT_FIFO_BSWAP_EN
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
`else
    return v;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] v);
    wr_valid = 1'b1;
    wr_data  = v;
    exp_q.push_back(xf(v));
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic pop_one();
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    exp_q.delete();
    tick();
    clr = 1'b0;
    blk_pulses = 0;
  endtask

  // Monitor: every accepted pop is compared against the scoreboard head
  always @(negedge clk) begin
    if (rstn && !clr && rd_valid && rd_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_pop_unexpected actual=0x%0h required=none at %0t", rd_data, $time);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          failures++;
          $display("FAIL sb_data actual=0x%0h required=0x%0h at %0t", rd_data, e, $time);
        end
      end
    end
    if (blk_done) blk_pulses++;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) tick();
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_udf", 32'(udf), 32'd0);
    chk("rst_blk_done", 32'(blk_done), 32'd0);
    rstn = 1'b1;
    tick();

    // 1: three pushes then three pops
    push(32'h1111_1111);
    chk("t1_valid_after_first", 32'(rd_valid), 32'd1);
    chk("t1_lvl1", 32'(level), 32'd1);
    push(32'h2222_2222);
    chk("t1_lvl2", 32'(level), 32'd2);
    push(32'h3333_3333);
    chk("t1_lvl3", 32'(level), 32'd3);
    for (int i = 2; i >= 0; i--) begin
      pop_one();
      chk("t1_pop_lvl", 32'(level), 32'(i));
    end
    chk("t1_empty", 32'(rd_valid), 32'd0);

    // 2: fill, overflow, drain
    do_clr();
    for (int i = 0; i < 128; i++) push(32'hA000_0000 + 32'(i));
    chk("t2_lvl128", 32'(level), 32'd128);
    chk("t2_full", 32'(wr_ready), 32'd0);
    wr_valid = 1'b1;
    wr_data  = 32'hDEAD_BEEF;
    tick();
    wr_valid = 1'b0;
    chk("t2_ovf", 32'(ovf), 32'd1);
    chk("t2_lvl_after_ovf", 32'(level), 32'd128);
    rd_ready = 1'b1;
    repeat (128) tick();
    rd_ready = 1'b0;
    chk("t2_drained", 32'(level), 32'd0);
    chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("t2_ovf_sticky", 32'(ovf), 32'd1);
    chk("t2_no_udf", 32'(udf), 32'd0);

    // 3: steady push+pop at level 5 across pointer wrap
    do_clr();
    for (int i = 0; i < 5; i++) push(32'h3000_0100 + 32'(i));
    wr_valid = 1'b1;
    rd_ready = 1'b1;
    for (int c = 0; c < 300; c++) begin
      wr_data = 32'h3000_0000 + 32'(c);
      exp_q.push_back(xf(wr_data));
      tick();
      if (c % 50 == 49) chk("t3_lvl5", 32'(level), 32'd5);
    end
    wr_valid = 1'b0;
    repeat (5) tick();
    rd_ready = 1'b0;
    chk("t3_drained", 32'(level), 32'd0);
    chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // 4: block boundary pulse, and clear mid-block
    do_clr();
    for (int i = 0; i < 128; i++) push(32'h4000_0000 + 32'(i));
    rd_ready = 1'b1;
    for (int i = 0; i < 128; i++) begin
      tick();
      if (i >= 126) chk("t4_blk_done", 32'(blk_done), (i == 127) ? 32'd1 : 32'd0);
    end
    rd_ready = 1'b0;
    tick();
    chk("t4_blk_done_drop", 32'(blk_done), 32'd0);
    chk("t4_pulses", 32'(blk_pulses), 32'd1);
    for (int i = 0; i < 128; i++) push(32'h4100_0000 + 32'(i));
    rd_ready = 1'b1;
    repeat (60) tick();
    rd_ready = 1'b0;
    do_clr();
    for (int i = 0; i < 128; i++) push(32'h4200_0000 + 32'(i));
    rd_ready = 1'b1;
    for (int i = 0; i < 128; i++) begin
      tick();
      if (i == 67 || i >= 126) chk("t4b_blk_done", 32'(blk_done), (i == 127) ? 32'd1 : 32'd0);
    end
    rd_ready = 1'b0;
    tick();
    chk("t4b_pulses", 32'(blk_pulses), 32'd1);

    // 5: underflow, then clear racing a push
    do_clr();
    pop_one();
    chk("t5_udf", 32'(udf), 32'd1);
    chk("t5_udf_lvl", 32'(level), 32'd0);
    for (int i = 0; i < 10; i++) push(32'h5000_0000 + 32'(i));
    chk("t5_lvl10", 32'(level), 32'd10);
    clr = 1'b1;
    wr_valid = 1'b1;
    wr_data = 32'h5555_5555;
    exp_q.delete();
    tick();
    clr = 1'b0;
    wr_valid = 1'b0;
    chk("t5_clr_lvl", 32'(level), 32'd0);
    chk("t5_clr_ovf", 32'(ovf), 32'd0);
    chk("t5_clr_udf", 32'(udf), 32'd0);
    chk("t5_clr_valid", 32'(rd_valid), 32'd0);
    chk("t5_clr_ready", 32'(wr_ready), 32'd1);

    // 6: byte order and threshold
    do_clr();
    push(32'h1234_5678);
`ifdef NEOSD_DAT_FIFO_BSWAP_EN
    chk("t6_bswap", rd_data, 32'h7856_3412);
`else
    chk("t6_noswap", rd_data, 32'h1234_5678);
`endif
    pop_one();
    thresh = 8'd64;
    for (int i = 1; i <= 128; i++) begin
      push(32'h6000_0000 + 32'(i));
      if (i >= 62 && i <= 66) chk("t6_thresh64", 32'(thresh_out), (i >= 64) ? 32'd1 : 32'd0);
    end
    thresh = 8'd200;
    #1;
    chk("t6_thresh_over_depth", 32'(thresh_out), 32'd0);
    thresh = 8'd128;
    #1;
    chk("t6_thresh_eq_depth", 32'(thresh_out), 32'd1);
    do_clr();
    thresh = 8'd0;
    #1;
    chk("t6_thresh_zero", 32'(thresh_out), 32'd1);
    thresh = 8'd1;
    #1;
    chk("t6_thresh_one_empty", 32'(thresh_out), 32'd0);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/neosd_dat_fifo.md
Name: neosd_dat_fifo

Overview:
Synchronous word FIFO between the Wishbone data-register path (offset 0x1C) and neosd_dat_fsm.
- Buffers one or more 512-byte SD blocks so software or DMA can burst data without per-word handshaking against the SD clock strobe.
- One instance per direction: TX (bus -> card) and RX (card -> bus). The block itself has no notion of direction.
- Reports fill level, threshold flag, sticky error flags and a block-boundary pulse to the top-level IRQ logic.

Parameters:
DEPTH, 128, storage depth in words; power of two, >= 4.
WIDTH, 32, data word width in bits.
BLOCK_WORDS, 128, words per SD block; used only for rd_blk_done_o; 1..DEPTH.

Ports:
clk_i  in  1  system clock
rstn_i  in  1  synchronous active-low reset
clr_i  in  1  synchronous flush (driven from CTRL.ABRT / CTRL.RST)
wr_data_i  in  WIDTH  push data
wr_valid_i  in  1  push request
wr_ready_o  out  1  space available (!full)
rd_data_o  out  WIDTH  head-of-queue word (first-word fall-through)
rd_valid_o  out  1  data available (!empty)
rd_ready_i  in  1  pop request
level_o  out  $clog2(DEPTH)+1  words currently stored, 0..DEPTH
thresh_i  in  $clog2(DEPTH)+1  threshold level
thresh_o  out  1  level_o >= thresh_i (combinational from registered level)
ovf_o  out  1  sticky overflow
udf_o  out  1  sticky underflow
rd_blk_done_o  out  1  one-cycle pulse when the last word of a block is popped

Behaviour:
- Clock and reset: single clock clk_i. rstn_i is synchronous and active-low, sampled on posedge clk_i.
- Reset values:
  - Pointers, level_o and block counter = 0.
  - wr_ready_o=1, rd_valid_o=0, ovf_o=0, udf_o=0, rd_blk_done_o=0.
  - rd_data_o is don't-care while rd_valid_o=0.
  - Memory contents are not reset.
- Push: occurs when wr_valid_i && wr_ready_o. The word is written at mem[wptr] and wptr increments modulo DEPTH.
- Pop: occurs when rd_valid_o && rd_ready_i. rptr increments modulo DEPTH.
- rd_data_o = mem[rptr], combinational read (FWFT).
- Latency:
  - A word pushed in cycle N gives rd_valid_o=1 and rd_data_o valid in cycle N+1.
  - No write-to-read bypass when empty.
- level update (modulo pointers plus a separate level counter, width $clog2(DEPTH)+1):
  - Push only: level_o +1.
  - Pop only: level_o -1.
  - Push and pop in the same cycle: level_o unchanged.
- Full (level_o==DEPTH): wr_ready_o=0. A simultaneous pop does not admit a push in that cycle.
- Empty (level_o==0): rd_valid_o=0.
- Overflow: wr_valid_i=1 while full sets ovf_o. The word is dropped and state is unchanged.
- Underflow: rd_ready_i=1 while empty sets udf_o. Pointers are unchanged.
- ovf_o and udf_o clear only on clr_i or reset.
- Block counter, range 0..BLOCK_WORDS-1:
  - Increments on each pop.
  - On a pop with counter==BLOCK_WORDS-1, the counter wraps to 0 and rd_blk_done_o pulses high in the next cycle (registered).
- clr_i:
  - Returns all state to reset values in the next cycle.
  - Has priority over a push or pop in the same cycle; that push or pop is discarded.
  - A pending rd_blk_done_o pulse is suppressed.
- Reset or clr_i mid-block discards the partial block count.
- thresh_i may change at any time. thresh_o follows combinationally.
- thresh_i=0 forces thresh_o=1. thresh_i>DEPTH forces thresh_o=0.

Optional Feature:
NEOSD_DAT_FIFO_BSWAP_EN
- Defined: the bytes of wr_data_i are reversed on push: {[7:0],[15:8],[23:16],[31:24]}. Little-endian CPU words are then sent MSB-first on DAT in the byte order held in memory. Requires WIDTH==32; elaboration error otherwise.
- Undefined: data is stored unmodified.
- Read path unaffected in both cases.

Decomposition:
- neosd_pkg holds:
  - NEOSD_FIFO_DEPTH=128 and NEOSD_BLOCK_WORDS=128 constants.
  - typedef neosd_word_t (logic[31:0]).
  - typedef neosd_level_t sized for the default DEPTH.
- Sub-module neosd_fifo_ram: DEPTH x WIDTH storage, synchronous write, asynchronous read. Keeps inference of distributed RAM separate from the control logic.

Test Plan:
1. Reset then push 0x11111111, 0x22222222, 0x33333333 -> rd_valid_o=1 one cycle after the first push; pops return values in order; level_o goes 1,2,3 then 2,1,0.
2. Push 128 words with rd_ready_i=0 -> wr_ready_o=0 at level 128; a 129th push with value 0xDEADBEEF sets ovf_o=1; popping all 128 returns the original data with no 0xDEADBEEF.
3. Continuous simultaneous push and pop at level 5 for 300 cycles -> level_o stays 5; pointers wrap past 127 with no data corruption.
4. Pop 128 words (BLOCK_WORDS=128) -> rd_blk_done_o is a single one-cycle pulse the cycle after the 128th pop; clr_i after 60 pops, then 128 more pops -> exactly one pulse, after pop 128 post-clear.
5. rd_ready_i=1 while empty -> udf_o=1; clr_i asserted in the same cycle as a push at level 10 -> next cycle level_o=0, ovf_o=udf_o=0, rd_valid_o=0.
6. With NEOSD_DAT_FIFO_BSWAP_EN, push 0x12345678 -> rd_data_o=0x78563412; without the macro -> rd_data_o=0x12345678; thresh_i=64 gives thresh_o=1 exactly from level_o=64.
